// File: rtl/display_pkg.sv
// Shared definitions for the display scheduler: state encoding, source geometry
// and the helper that extracts one requester's word from the packed data bus.
package display_pkg;

  localparam int NUM_SRC = 4;
  localparam int SEG_W   = 32;
  localparam int IDX_W   = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SHOW = 2'd1;
  localparam logic [1:0] ST_PIN  = 2'd2;

  // Source i occupies bits [SEG_W*i +: SEG_W] of the packed data bus.
  function automatic logic [SEG_W-1:0] src_slice(
    input logic [NUM_SRC*SEG_W-1:0] data,
    input logic [IDX_W-1:0]         idx
  );
    return data[int'(idx)*SEG_W +: SEG_W];
  endfunction

endpackage

// File: rtl/display_scheduler_if.sv
// Requester-side and display-side signals of the display scheduler.
interface display_scheduler_if;
  import display_pkg::*;

  logic [NUM_SRC-1:0]       src_req;
  logic [NUM_SRC*SEG_W-1:0] src_data;
  logic                     pin_en;
  logic [IDX_W-1:0]         pin_sel;
  logic [NUM_SRC-1:0]       src_grant;
  logic [IDX_W-1:0]         cur_src;
  logic                     cur_valid;
  logic [SEG_W-1:0]         seg;

  modport master (
    output src_req, src_data, pin_en, pin_sel,
    input  src_grant, cur_src, cur_valid, seg
  );

  modport slave (
    input  src_req, src_data, pin_en, pin_sel,
    output src_grant, cur_src, cur_valid, seg
  );
endinterface

// File: rtl/display_scheduler_rr_picker.sv
// Round-robin picker: first requesting index after `last`, wrapping modulo 4;
// `last` itself is checked last, so a lone requester can be re-picked.
module rr_picker
  import display_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [IDX_W-1:0]   pick,
  output logic               any
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    pick = '0;
    any  = 1'b0;
    idx  = '0;
    // Scan from the farthest offset down so the nearest requester wins.
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx = last + IDX_W'(k);
      if (req[idx]) begin
        pick = idx;
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_scheduler.sv
// Round-robin dwell scheduler that time-shares the seven-segment display among
// four requesters, with a manual pin override; all outputs are registered.
module display_scheduler
  import display_pkg::*;
#(
  parameter int DWELL_CYCLES = 100_000_000,
  parameter int CNT_W        = 27
) (
  input  logic               clk,
  input  logic               reset,
  display_scheduler_if.slave bus
);

  logic [1:0]         state, nxt_state;
  logic [IDX_W-1:0]   last, nxt_last, nxt_src;
  logic [CNT_W-1:0]   cnt, nxt_cnt;
  logic [IDX_W-1:0]   pick;
  logic               any;
  logic               expired;

  logic [NUM_SRC-1:0] grant_p1;
  logic [IDX_W-1:0]   src_p1;
  logic               vld_p1;
  logic [SEG_W-1:0]   seg_p1;

  rr_picker u_picker (
    .req  (bus.src_req),
    .last (last),
    .pick (pick),
    .any  (any)
  );

  assign expired = (cnt == CNT_W'(DWELL_CYCLES - 1));

  always_comb begin
    nxt_state = state;
    nxt_src   = src_p1;
    nxt_cnt   = '0;
    if (bus.pin_en) begin
      nxt_state = ST_PIN;
      nxt_src   = bus.pin_sel;
    end else if (state == ST_SHOW && bus.src_req[src_p1] && !expired) begin
      nxt_cnt   = cnt + CNT_W'(1);
    end else if (state != ST_IDLE || any) begin
      // Covers leaving PIN, waking from IDLE, a request drop and dwell expiry.
      nxt_state = any ? ST_SHOW : ST_IDLE;
      nxt_src   = any ? pick : src_p1;
    end
    nxt_last = (nxt_state != ST_IDLE) ? nxt_src : last;
  end

  // Stage p1: state and registered display outputs, all updated on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      last     <= IDX_W'(NUM_SRC - 1);
      cnt      <= '0;
      grant_p1 <= '0;
      src_p1   <= '0;
      vld_p1   <= 1'b0;
      seg_p1   <= '0;
    end else begin
      state    <= nxt_state;
      last     <= nxt_last;
      cnt      <= nxt_cnt;
      src_p1   <= nxt_src;
      vld_p1   <= (nxt_state != ST_IDLE);
      grant_p1 <= (nxt_state != ST_IDLE) ? (NUM_SRC'(1) << nxt_src) : '0;
      seg_p1   <= (nxt_state != ST_IDLE) ? src_slice(bus.src_data, nxt_src) : '0;
    end
  end

  assign bus.src_grant = grant_p1;
  assign bus.cur_src   = src_p1;
  assign bus.cur_valid = vld_p1;
  assign bus.seg       = seg_p1;

endmodule

// File: doc/display_scheduler.md
# display_scheduler

Time-shares the 8-digit seven-segment display between up to four 32-bit requesters (e.g. register-file read ports, ALU result, PC) with round-robin dwell scheduling and a manual pin override. Sits directly upstream of `display_controller`: its registered `seg` output drives that block's 32-bit `seg` input, and it runs on the same 100 MHz board clock.

## Interface
- `NUM_SRC`, 4: number of requesters; fixed at 4 in this revision.
- `DWELL_CYCLES`, 100_000_000: clock cycles each source is shown before rotating (1 s at 100 MHz); must be at least 2.
- `CNT_W`, 27: dwell counter width; must satisfy 2^CNT_W ≥ DWELL_CYCLES.
- `clk`  in  1  board clock, 100 MHz; all state changes on its rising edge.
- `reset`  in  1  one clock; reset is asynchronous and active-low (the block is in reset while `reset` = 0).
- `src_req`  in  4  per-source request; bit i high = source i wants display time.
- `src_data`  in  128  source i data on bits [32i+31:32i].
- `pin_en`  in  1  manual override; forces `pin_sel` onto the display.
- `pin_sel`  in  2  source index to pin.
- `src_grant`  out  4  one-hot grant; all zero when idle.
- `cur_src`  out  2  index of the displayed source.
- `cur_valid`  out  1  high in SHOW or PIN.
- `seg`  out  32  registered display word to `display_controller`.

## Operation
- States: IDLE, SHOW, PIN.
- Reset values: IDLE, `src_grant` = 0, `cur_src` = 0, `cur_valid` = 0, `seg` = 0, dwell counter = 0, round-robin pointer `last` = 3 (so source 0 is checked first).
- Round-robin pick: scan indices `last`+1, `last`+2, … modulo 4; take the first index whose `src_req` bit is set.
- IDLE:
  - `pin_en` high → PIN.
  - Otherwise, any `src_req` bit high → SHOW with the picked source; counter cleared.
- SHOW, priority order:
  - `pin_en` high → PIN.
  - Granted source's `src_req` drops → pick next requester with counter cleared; if none is requesting → IDLE.
  - Counter = `DWELL_CYCLES`−1 → pick next requester with counter cleared. If the current source is the only requester, it is re-granted and the counter restarts.
  - Otherwise the counter increments.
- PIN:
  - Grant = one-hot(`pin_sel`), independent of `src_req`.
  - `pin_sel` may change while in PIN; the grant follows it on the next edge.
  - Counter is held at 0.
  - `pin_en` low → SHOW if any requester (pick with `last` = the pinned index), else IDLE.
- `last` updates to the newly granted index on every grant change.
- `seg` each cycle:
  - SHOW/PIN: loads `src_data` of the next-state grant.
  - IDLE: loads 0. The display blanks to "00000000".
- No arithmetic beyond the counter. Counter compare is an unsigned equality at `DWELL_CYCLES`−1; it never wraps past that value.

## Timing
- All outputs are registered. `src_grant`, `cur_src`, `cur_valid` and `seg` change on the same edge.
- Data latency: `src_data` change → `seg` change is 1 cycle.
- Request latency: `src_req` rising in IDLE → grant on the next edge.
- A request drop is seen on the next edge. There is no dead cycle between consecutive grants.
- Dwell: a source granted at edge t, with `src_req` held, loses its grant at edge t + `DWELL_CYCLES`.
- Simultaneous `pin_en` rise and dwell expiry: PIN wins.
- Simultaneous request drop and expiry: treated as a drop (same result).
- Asynchronous reset mid-dwell: outputs go to reset values immediately, without waiting for a clock edge. Deassertion is synchronised externally.

## Structure
- Shared package `display_pkg` holds:
  - the state encoding (IDLE = 2'd0, SHOW = 2'd1, PIN = 2'd2);
  - `NUM_SRC` and `SEG_W` = 32;
  - the slice helper convention for `src_data`.
- One combinational sub-module, `rr_picker`:
  - inputs: `req`[3:0], `last`[1:0];
  - outputs: `pick`[1:0], `any`.
- The FSM, dwell counter and output registers sit in `display_scheduler`.

## Test plan
All scenarios use `DWELL_CYCLES` = 8, `CNT_W` = 4.
- Reset: hold `reset` = 0 with `src_req` = 4'b1111 → `seg` = 0, `src_grant` = 0, `cur_valid` = 0. Release `reset` → next edge `src_grant` = 4'b0001.
- Rotation: `src_req` = 4'b1011 with data 0x11111111/0x22222222/–/0x44444444 → sources 0, 1, 3, 0 shown for 8 cycles each; `seg` matches the granted data; source 2 is never granted.
- Single requester: `src_req` = 4'b0100 → grant stays 4'b0100 across 3 dwell periods; counter restarts at each expiry.
- Early drop: source 1 granted, drop `src_req[1]` at dwell cycle 3 → next edge grants source 3. Drop all requests → IDLE, `seg` = 0.
- Pin override: in SHOW, set `pin_en` = 1, `pin_sel` = 2 with `src_req[2]` = 0 → next edge `src_grant` = 4'b0100 and `seg` = src_data[95:64]. Release `pin_en` → next requester after 2 is granted.
- Live data: with source 0 granted, change `src_data[31:0]` to 0xDEADBEEF → `seg` = 0xDEADBEEF exactly 1 cycle later.
